// File: rtl/openhmc_mon_pkg.sv
// rtl/openhmc_mon_pkg.sv - shared error type codes and bit-index helper for the openHMC AXIS monitor
package openhmc_mon_pkg;

    // Error type codes as reported in first_err_type
    typedef enum logic [2:0] {
        ERR_VALID_DROP    = 3'd0,
        ERR_DATA_CHANGE   = 3'd1,
        ERR_USER_CHANGE   = 3'd2,
        ERR_STALL_TIMEOUT = 3'd3,
        ERR_RF_RW         = 3'd4
    } err_type_e;

    // Per-channel error types; RF_RW lives in the single MSB above all channel fields
    localparam int ERR_TYPES = 4;

    // Position of channel ch, type t inside err_sticky / err_mask
    function automatic int err_bit_index(input int ch, input int t);
        return ch * ERR_TYPES + t;
    endfunction

endpackage

// File: rtl/openhmc_axis_ch_checker.sv
// rtl/openhmc_axis_ch_checker.sv - per-channel AXI-Stream hold-until-ready and stall-timeout checker
module openhmc_axis_ch_checker
    import openhmc_mon_pkg::*;
#(
    parameter int DWIDTH        = 512,
    parameter int UWIDTH        = 32,
    parameter int STALL_TIMEOUT = 1024
) (
    input  logic                 clk_hmc,
    input  logic                 res_n_hmc,
    input  logic                 tvalid,
    input  logic                 tready,
    input  logic [DWIDTH-1:0]    tdata,
    input  logic [UWIDTH-1:0]    tuser,
    input  logic                 enable,
    output logic [ERR_TYPES-1:0] err
);

    // Counter must be able to hold STALL_TIMEOUT itself, where it saturates
    localparam int CW = $clog2(STALL_TIMEOUT + 1);

    logic              stall_now;
    logic              stall_q;
    logic [DWIDTH-1:0] data_q;
    logic [UWIDTH-1:0] user_q;
    logic [CW-1:0]     cnt_q;
    logic [CW-1:0]     cnt_next;
    logic              timeout_hit;

    // A stall cycle only counts while this channel is being monitored
    assign stall_now = tvalid & ~tready & enable;

    // Timeout fires exactly once: when the run including this cycle first reaches the limit
    assign timeout_hit = stall_now & (cnt_q == CW'(STALL_TIMEOUT - 1));

    // Consecutive-stall counter: saturates, and any non-stall cycle restarts the run
    always_comb begin
        cnt_next = '0;
        if (stall_now) begin
            if (cnt_q == CW'(STALL_TIMEOUT)) begin
                cnt_next = cnt_q;
            end else begin
                cnt_next = cnt_q + 1'b1;
            end
        end
    end

    // Stall flag, stall counter and the beat snapshot that must be held next cycle
    always_ff @(posedge clk_hmc or negedge res_n_hmc) begin
        if (!res_n_hmc) begin
            stall_q <= 1'b0;
            cnt_q   <= '0;
            data_q  <= '0;
            user_q  <= '0;
        end else begin
            stall_q <= stall_now;
            cnt_q   <= cnt_next;
            if (stall_now) begin
                data_q <= tdata;
                user_q <= tuser;
            end
        end
    end

    // Hold-until-ready checks against the beat stalled in the previous cycle
    always_comb begin
        err = '0;
        if (enable && stall_q) begin
            if (!tvalid) begin
                err[int'(ERR_VALID_DROP)] = 1'b1;
            end else begin
                err[int'(ERR_DATA_CHANGE)] = (tdata != data_q);
                err[int'(ERR_USER_CHANGE)] = (tuser != user_q);
            end
        end
        err[int'(ERR_STALL_TIMEOUT)] = timeout_hit;
    end

endmodule

// File: rtl/openhmc_axis_protocol_monitor.sv
// rtl/openhmc_axis_protocol_monitor.sv - multi-channel AXI-Stream protocol monitor with sticky flags, counters, capture and irq
module openhmc_axis_protocol_monitor
    import openhmc_mon_pkg::*;
#(
    parameter int NUM_CH        = 2,
    parameter int DWIDTH        = 512,
    parameter int UWIDTH        = 32,
    parameter int STALL_TIMEOUT = 1024,
    parameter int CNT_WIDTH     = 16,
    parameter int TS_WIDTH      = 32
) (
    input  logic                            clk_hmc,
    input  logic                            res_n_hmc,
    input  logic [NUM_CH-1:0]               axis_tvalid,
    input  logic [NUM_CH-1:0]               axis_tready,
    input  logic [NUM_CH*DWIDTH-1:0]        axis_tdata,
    input  logic [NUM_CH*UWIDTH-1:0]        axis_tuser,
    input  logic                            rf_read_en,
    input  logic                            rf_write_en,
    input  logic [NUM_CH-1:0]               mon_enable,
    input  logic                            err_clear,
    input  logic [NUM_CH*ERR_TYPES:0]       err_mask,
    output logic [NUM_CH*ERR_TYPES:0]       err_sticky,
    output logic [NUM_CH*CNT_WIDTH-1:0]     err_count,
    output logic                            first_err_valid,
    output logic [3:0]                      first_err_ch,
    output logic [2:0]                      first_err_type,
    output logic [TS_WIDTH-1:0]             first_err_time,
    output logic                            irq
);

    localparam int NBITS = NUM_CH * ERR_TYPES + 1;

    logic [ERR_TYPES-1:0] ch_err [NUM_CH];
    logic [NUM_CH-1:0]    ch_any;
    logic                 rf_err;
    logic [NBITS-1:0]     new_err;
    logic                 cap_hit;
    logic [3:0]           cap_ch;
    logic [2:0]           cap_type;
    logic [TS_WIDTH-1:0]  ts_q;

    assign rf_err = rf_read_en & rf_write_en;

    genvar c;
    generate
        for (c = 0; c < NUM_CH; c++) begin : g_ch
            logic [CNT_WIDTH-1:0] cnt_q;

            openhmc_axis_ch_checker #(
                .DWIDTH        (DWIDTH),
                .UWIDTH        (UWIDTH),
                .STALL_TIMEOUT (STALL_TIMEOUT)
            ) u_checker (
                .clk_hmc   (clk_hmc),
                .res_n_hmc (res_n_hmc),
                .tvalid    (axis_tvalid[c]),
                .tready    (axis_tready[c]),
                .tdata     (axis_tdata[c*DWIDTH +: DWIDTH]),
                .tuser     (axis_tuser[c*UWIDTH +: UWIDTH]),
                .enable    (mon_enable[c]),
                .err       (ch_err[c])
            );

            assign ch_any[c] = |ch_err[c];

            // One count per violation cycle; a clear colliding with a new error restarts at 1
            always_ff @(posedge clk_hmc or negedge res_n_hmc) begin
                if (!res_n_hmc) begin
                    cnt_q <= '0;
                end else if (err_clear) begin
                    cnt_q <= ch_any[c] ? CNT_WIDTH'(1) : '0;
                end else if (ch_any[c] && (cnt_q != '1)) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end

            assign err_count[c*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
        end
    endgenerate

    // Flatten per-channel error vectors into the sticky-flag layout
    always_comb begin
        new_err = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            for (int t = 0; t < ERR_TYPES; t++) begin
                new_err[err_bit_index(ch, t)] = ch_err[ch][t];
            end
        end
        new_err[NBITS-1] = rf_err;
    end

    // Priority pick: lowest channel, then lowest type; RF_RW only when no channel error
    always_comb begin
        cap_hit  = 1'b0;
        cap_ch   = '0;
        cap_type = '0;
        for (int ch = NUM_CH - 1; ch >= 0; ch--) begin
            for (int t = ERR_TYPES - 1; t >= 0; t--) begin
                if (ch_err[ch][t]) begin
                    cap_hit  = 1'b1;
                    cap_ch   = 4'(ch);
                    cap_type = 3'(t);
                end
            end
        end
        if (!cap_hit && rf_err) begin
            cap_hit  = 1'b1;
            cap_ch   = '0;
            cap_type = ERR_RF_RW;
        end
    end

    // Free-running timestamp used to stamp the first error
    always_ff @(posedge clk_hmc or negedge res_n_hmc) begin
        if (!res_n_hmc) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + 1'b1;
        end
    end

    // Sticky flags; on a clear only the errors of the clearing cycle survive
    always_ff @(posedge clk_hmc or negedge res_n_hmc) begin
        if (!res_n_hmc) begin
            err_sticky <= '0;
        end else if (err_clear) begin
            err_sticky <= new_err;
        end else begin
            err_sticky <= err_sticky | new_err;
        end
    end

    // First-error capture, reloaded by a new error that collides with a clear
    always_ff @(posedge clk_hmc or negedge res_n_hmc) begin
        if (!res_n_hmc) begin
            first_err_valid <= 1'b0;
            first_err_ch    <= '0;
            first_err_type  <= '0;
            first_err_time  <= '0;
        end else if ((err_clear || !first_err_valid) && cap_hit) begin
            first_err_valid <= 1'b1;
            first_err_ch    <= cap_ch;
            first_err_type  <= cap_type;
            first_err_time  <= ts_q;
        end else if (err_clear) begin
            first_err_valid <= 1'b0;
            first_err_ch    <= '0;
            first_err_type  <= '0;
            first_err_time  <= '0;
        end
    end

    assign irq = |(err_sticky & err_mask);

endmodule

// File: tb/tb_openhmc_axis_protocol_monitor.sv
// tb/tb_openhmc_axis_protocol_monitor.sv - self-checking bench for openhmc_axis_protocol_monitor
module tb_openhmc_axis_protocol_monitor;

    localparam int NCH = 2;
    localparam int DW  = 16;
    localparam int UW  = 8;
    localparam int TO  = 4;
    localparam int CW  = 2;
    localparam int TSW = 16;
    localparam int NB  = NCH * 4 + 1;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NCH-1:0]  tvalid = '0;
    logic [NCH-1:0]  tready = '0;
    logic [NCH*DW-1:0] tdata = '0;
    logic [NCH*UW-1:0] tuser = '0;
    logic            rf_r = 1'b0;
    logic            rf_w = 1'b0;
    logic [NCH-1:0]  en = '1;
    logic            clr = 1'b0;
    logic [NB-1:0]   mask = '0;
    logic [NB-1:0]   sticky;
    logic [NCH*CW-1:0] count;
    logic            fv;
    logic [3:0]      fch;
    logic [2:0]      ftype;
    logic [TSW-1:0]  ftime;
    logic            irq;

    int tests = 0;
    int fails = 0;

    // Reference model state, in terms of the protocol rules
    bit             m_held [NCH];
    logic [DW-1:0]  m_hd   [NCH];
    logic [UW-1:0]  m_hu   [NCH];
    int             m_run  [NCH];
    logic [NB-1:0]  m_sticky;
    int             m_cnt  [NCH];
    bit             m_fv;
    int             m_fch;
    int             m_ft;
    int             m_ftime;
    int             m_ts;

    openhmc_axis_protocol_monitor #(
        .NUM_CH(NCH), .DWIDTH(DW), .UWIDTH(UW), .STALL_TIMEOUT(TO),
        .CNT_WIDTH(CW), .TS_WIDTH(TSW)
    ) dut (
        .clk_hmc(clk), .res_n_hmc(rst_n),
        .axis_tvalid(tvalid), .axis_tready(tready),
        .axis_tdata(tdata), .axis_tuser(tuser),
        .rf_read_en(rf_r), .rf_write_en(rf_w),
        .mon_enable(en), .err_clear(clr), .err_mask(mask),
        .err_sticky(sticky), .err_count(count),
        .first_err_valid(fv), .first_err_ch(fch),
        .first_err_type(ftype), .first_err_time(ftime), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_held[c] = 0; m_hd[c] = '0; m_hu[c] = '0; m_run[c] = 0; m_cnt[c] = 0;
        end
        m_sticky = '0; m_fv = 0; m_fch = 0; m_ft = 0; m_ftime = 0; m_ts = 0;
    endtask

    // One clock of the reference model using the inputs currently applied
    task automatic model_step();
        logic [NB-1:0] ne;
        bit found;
        int fc, ft;
        ne = '0;
        for (int c = 0; c < NCH; c++) begin
            logic [DW-1:0] d;
            logic [UW-1:0] u;
            bit stall;
            d = tdata[c*DW +: DW];
            u = tuser[c*UW +: UW];
            if (en[c] && m_held[c]) begin
                if (!tvalid[c]) ne[c*4+0] = 1'b1;
                else begin
                    if (d != m_hd[c]) ne[c*4+1] = 1'b1;
                    if (u != m_hu[c]) ne[c*4+2] = 1'b1;
                end
            end
            stall = tvalid[c] && !tready[c] && en[c];
            m_run[c] = stall ? m_run[c] + 1 : 0;
            if (stall && m_run[c] == TO) ne[c*4+3] = 1'b1;
            m_held[c] = stall;
            m_hd[c] = d;
            m_hu[c] = u;
        end
        ne[NB-1] = rf_r & rf_w;
        found = 0; fc = 0; ft = 0;
        for (int c = 0; c < NCH; c++)
            for (int t = 0; t < 4; t++)
                if (!found && ne[c*4+t]) begin found = 1; fc = c; ft = t; end
        if (!found && ne[NB-1]) begin found = 1; fc = 0; ft = 4; end
        m_sticky = clr ? ne : (m_sticky | ne);
        for (int c = 0; c < NCH; c++) begin
            int a;
            a = (ne[c*4 +: 4] != 0) ? 1 : 0;
            if (clr) m_cnt[c] = a;
            else m_cnt[c] = (m_cnt[c] + a > CNT_MAX) ? CNT_MAX : m_cnt[c] + a;
        end
        if ((clr || !m_fv) && found) begin
            m_fv = 1; m_fch = fc; m_ft = ft; m_ftime = m_ts;
        end else if (clr) begin
            m_fv = 0; m_fch = 0; m_ft = 0; m_ftime = 0;
        end
        m_ts = (m_ts + 1) % (1 << TSW);
    endtask

    task automatic tick();
        if (!rst_n) model_reset();
        else model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".sticky"}, 32'(sticky), 32'(m_sticky));
        for (int c = 0; c < NCH; c++)
            chk({tag, ".count"}, 32'(count[c*CW +: CW]), 32'(m_cnt[c]));
        chk({tag, ".fv"}, 32'(fv), 32'(m_fv));
        chk({tag, ".fch"}, 32'(fch), 32'(m_fch));
        chk({tag, ".ftype"}, 32'(ftype), 32'(m_ft));
        chk({tag, ".ftime"}, 32'(ftime), 32'(m_ftime));
        chk({tag, ".irq"}, 32'(irq), 32'(|(m_sticky & mask)));
    endtask

    task automatic idle();
        tvalid = '0; tready = '0; tdata = '0; tuser = '0;
        rf_r = 0; rf_w = 0; clr = 0; en = '1;
    endtask

    typedef struct packed {
        logic [1:0]  v;
        logic [1:0]  r;
        logic [15:0] d0;
        logic [15:0] d1;
        logic [7:0]  u0;
        logic [7:0]  u1;
        logic        rfr;
        logic        rfw;
        logic        clr;
        logic [8:0]  mask;
        logic [8:0]  e_sticky;
        logic [1:0]  e_c0;
        logic [1:0]  e_c1;
        logic        e_fv;
        logic [3:0]  e_fch;
        logic [2:0]  e_ft;
        logic [15:0] e_time;
        logic        e_irq;
    } vec_t;

    vec_t tbl [15];

    initial begin
        tbl[0]  = '{2'b00, 2'b00, 16'h0,    16'h0, 8'h0, 8'h00, 1'b0, 1'b0, 1'b0, 9'h000, 9'h000, 2'd0, 2'd0, 1'b0, 4'd0, 3'd0, 16'd0,  1'b0};
        tbl[1]  = '{2'b01, 2'b00, 16'h1111, 16'h0, 8'h0, 8'h00, 1'b0, 1'b0, 1'b0, 9'h000, 9'h000, 2'd0, 2'd0, 1'b0, 4'd0, 3'd0, 16'd0,  1'b0};
        tbl[2]  = '{2'b01, 2'b00, 16'h2222, 16'h0, 8'h0, 8'h00, 1'b0, 1'b0, 1'b0, 9'h000, 9'h002, 2'd1, 2'd0, 1'b1, 4'd0, 3'd1, 16'd2,  1'b0};
        tbl[3]  = '{2'b01, 2'b01, 16'h2222, 16'h0, 8'h0, 8'h00, 1'b0, 1'b0, 1'b0, 9'h1FF, 9'h002, 2'd1, 2'd0, 1'b1, 4'd0, 3'd1, 16'd2,  1'b1};
        tbl[4]  = '{2'b11, 2'b00, 16'h3333, 16'h0, 8'h0, 8'h55, 1'b0, 1'b0, 1'b0, 9'h000, 9'h002, 2'd1, 2'd0, 1'b1, 4'd0, 3'd1, 16'd2,  1'b0};
        tbl[5]  = '{2'b10, 2'b00, 16'h3333, 16'h0, 8'h0, 8'h66, 1'b0, 1'b0, 1'b0, 9'h000, 9'h043, 2'd2, 2'd1, 1'b1, 4'd0, 3'd1, 16'd2,  1'b0};
        tbl[6]  = '{2'b10, 2'b10, 16'h0,    16'h0, 8'h0, 8'h66, 1'b0, 1'b0, 1'b1, 9'h000, 9'h000, 2'd0, 2'd0, 1'b0, 4'd0, 3'd0, 16'd0,  1'b0};
        tbl[7]  = '{2'b00, 2'b00, 16'h0,    16'h0, 8'h0, 8'h00, 1'b1, 1'b1, 1'b1, 9'h0FF, 9'h100, 2'd0, 2'd0, 1'b1, 4'd0, 3'd4, 16'd7,  1'b0};
        tbl[8]  = '{2'b00, 2'b00, 16'h0,    16'h0, 8'h0, 8'h00, 1'b0, 1'b0, 1'b0, 9'h100, 9'h100, 2'd0, 2'd0, 1'b1, 4'd0, 3'd4, 16'd7,  1'b1};
        tbl[9]  = '{2'b00, 2'b00, 16'h0,    16'h0, 8'h0, 8'h00, 1'b1, 1'b1, 1'b0, 9'h000, 9'h100, 2'd0, 2'd0, 1'b1, 4'd0, 3'd4, 16'd7,  1'b0};
        tbl[10] = '{2'b00, 2'b00, 16'h0,    16'h0, 8'h0, 8'h00, 1'b0, 1'b0, 1'b1, 9'h000, 9'h000, 2'd0, 2'd0, 1'b0, 4'd0, 3'd0, 16'd0,  1'b0};
        tbl[11] = '{2'b11, 2'b00, 16'h3333, 16'h0, 8'h0, 8'h55, 1'b0, 1'b0, 1'b0, 9'h000, 9'h000, 2'd0, 2'd0, 1'b0, 4'd0, 3'd0, 16'd0,  1'b0};
        tbl[12] = '{2'b10, 2'b00, 16'h3333, 16'h0, 8'h0, 8'h77, 1'b0, 1'b0, 1'b0, 9'h000, 9'h041, 2'd1, 2'd1, 1'b1, 4'd0, 3'd0, 16'd12, 1'b0};
        tbl[13] = '{2'b00, 2'b00, 16'h0,    16'h0, 8'h0, 8'h00, 1'b0, 1'b0, 1'b1, 9'h000, 9'h010, 2'd0, 2'd1, 1'b1, 4'd1, 3'd0, 16'd13, 1'b0};
        tbl[14] = '{2'b00, 2'b00, 16'h0,    16'h0, 8'h0, 8'h00, 1'b0, 1'b0, 1'b1, 9'h000, 9'h000, 2'd0, 2'd0, 1'b0, 4'd0, 3'd0, 16'd0,  1'b0};

        // Reset state
        idle();
        mask = '1;
        rst_n = 0;
        tick();
        tick();
        chk("reset.sticky", 32'(sticky), 32'd0);
        chk("reset.count", 32'(count), 32'd0);
        chk("reset.fv", 32'(fv), 32'd0);
        chk("reset.ftime", 32'(ftime), 32'd0);
        chk("reset.irq", 32'(irq), 32'd0);
        mask = '0;
        rst_n = 1;

        // Directed table: hold violation, priority, RF/clear collisions
        for (int i = 0; i < 15; i++) begin
            tvalid = tbl[i].v; tready = tbl[i].r;
            tdata = {tbl[i].d1, tbl[i].d0}; tuser = {tbl[i].u1, tbl[i].u0};
            rf_r = tbl[i].rfr; rf_w = tbl[i].rfw; clr = tbl[i].clr; mask = tbl[i].mask;
            tick();
            check_all("tbl_model");
            chk($sformatf("tbl%0d.sticky", i), 32'(sticky), 32'(tbl[i].e_sticky));
            chk($sformatf("tbl%0d.cnt0", i), 32'(count[1:0]), 32'(tbl[i].e_c0));
            chk($sformatf("tbl%0d.cnt1", i), 32'(count[3:2]), 32'(tbl[i].e_c1));
            chk($sformatf("tbl%0d.fv", i), 32'(fv), 32'(tbl[i].e_fv));
            chk($sformatf("tbl%0d.fch", i), 32'(fch), 32'(tbl[i].e_fch));
            chk($sformatf("tbl%0d.ftype", i), 32'(ftype), 32'(tbl[i].e_ft));
            chk($sformatf("tbl%0d.ftime", i), 32'(ftime), 32'(tbl[i].e_time));
            chk($sformatf("tbl%0d.irq", i), 32'(irq), 32'(tbl[i].e_irq));
        end
        idle(); mask = '0;

        // Counter saturation: five separate VALID_DROP violations on ch0
        for (int k = 0; k < 5; k++) begin
            tvalid[0] = 1; tready[0] = 0; tick(); check_all("sat");
            tvalid[0] = 0; tick(); check_all("sat");
        end
        chk("sat.cnt0", 32'(count[1:0]), 32'd3);
        chk("sat.sticky", 32'(sticky), 32'h001);
        clr = 1; tick(); check_all("sat_clr"); clr = 0;

        // Stall timeout on ch1: eleven stall cycles, one report at the fourth
        tdata[31:16] = 16'hBEEF; tuser[15:8] = 8'h5A;
        for (int i = 1; i <= 11; i++) begin
            tvalid[1] = 1; tready[1] = 0;
            tick();
            check_all("stall");
            if (i == 3) chk("stall.before", 32'(sticky), 32'h000);
            if (i == 4) chk("stall.hit", 32'(sticky), 32'h080);
        end
        chk("stall.after", 32'(sticky), 32'h080);
        chk("stall.cnt1", 32'(count[3:2]), 32'd1);
        chk("stall.ftype", 32'(ftype), 32'd3);
        tready[1] = 1; tick(); check_all("stall_hs");
        chk("stall.hs", 32'(sticky), 32'h080);
        idle(); clr = 1; tick(); check_all("stall_clr"); clr = 0;

        // Reset asserted mid-stall, released with valid low
        tvalid[0] = 1; tready[0] = 0; tdata[15:0] = 16'h1234;
        tick(); tick();
        rst_n = 0;
        #1;
        model_reset();
        chk("rst_mid.sticky", 32'(sticky), 32'd0);
        chk("rst_mid.count", 32'(count), 32'd0);
        tick();
        tvalid[0] = 0;
        rst_n = 1;
        tick();
        check_all("rst_rel");
        chk("rst_rel.sticky", 32'(sticky), 32'd0);
        chk("rst_rel.fv", 32'(fv), 32'd0);

        // mon_enable toggled during a stall reports nothing
        tvalid[0] = 1; tready[0] = 0; tdata[15:0] = 16'hAAAA; tick(); check_all("en");
        en[0] = 0; tdata[15:0] = 16'hBBBB; tick(); check_all("en");
        en[0] = 1; tdata[15:0] = 16'hCCCC; tick(); check_all("en");
        tick(); check_all("en");
        en[0] = 0; tvalid[0] = 0; tick(); check_all("en");
        en[0] = 1; tick(); check_all("en");
        chk("en.sticky", 32'(sticky), 32'd0);
        idle();

        // Randomized traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < NCH; c++) begin
                tvalid[c] = ($urandom_range(0, 9) < 7);
                tready[c] = $urandom_range(0, 1);
                en[c] = ($urandom_range(0, 19) != 0);
                if ($urandom_range(0, 3) == 0) tdata[c*DW +: DW] = DW'($urandom_range(0, 3));
                if ($urandom_range(0, 5) == 0) tuser[c*UW +: UW] = UW'($urandom_range(0, 1));
            end
            rf_r = ($urandom_range(0, 7) == 0);
            rf_w = ($urandom_range(0, 3) == 0);
            clr = ($urandom_range(0, 39) == 0);
            mask = NB'($urandom);
            tick();
            check_all("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
